// File: rtl/booth_radix4_mul.sv
// booth_radix4_mul: sequential radix-4 Booth multiplier for signed or unsigned
// N-bit operands. It retires one Booth digit per RUN cycle on an (N+2)-bit
// operand copy and produces the 2N-bit product after N/2+1 RUN cycles.
module booth_radix4_mul #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   // Two guard bits let unsigned operands ride through the signed recoder.
   localparam int W  = N + 2;
   localparam int CW = $clog2(W / 2 + 1);
   localparam logic [CW-1:0] ITERS = CW'(W / 2);
   localparam logic [CW-1:0] LAST  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic signed [W:0]   a_q, a_d;
   logic [W-1:0]        q_q, q_d;
   logic                qm1_q, qm1_d;
   logic signed [W-1:0] m_q, m_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*N-1:0]      prod_q, prod_d;
   logic signed [W:0]   sum;
   logic                accept;

   // Widen an operand to W bits, sign- or zero-extending per mode.
   function automatic logic signed [W-1:0] extend_op(input logic [N-1:0] v,
                                                     input logic        sgn);
      extend_op = sgn ? {{2{v[N-1]}}, v} : {2'b00, v};
   endfunction

   // Partial product selected by one radix-4 Booth digit, at accumulator width.
   function automatic logic signed [W:0] booth_pp(input logic [2:0]          dig,
                                                  input logic signed [W-1:0] m);
      logic signed [W:0] m1;
      logic signed [W:0] m2;
      m1 = {m[W-1], m};
      m2 = {m, 1'b0};
      case (dig)
         3'b001, 3'b010: booth_pp = m1;
         3'b011:         booth_pp = m2;
         3'b100:         booth_pp = -m2;
         3'b101, 3'b110: booth_pp = -m1;
         default:        booth_pp = '0;
      endcase
   endfunction

   // A new operation may start from IDLE or from the DONE cycle, never mid-run.
   assign accept = start && (state_q != S_RUN);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: RUN ends on the cycle whose decrement empties the counter.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: status flags are pure functions of the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: load on accept, then add-and-shift one Booth digit per RUN cycle.
   always_comb begin
      a_d    = a_q;
      q_d    = q_q;
      qm1_d  = qm1_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      prod_d = prod_q;
      sum    = a_q + booth_pp({q_q[1:0], qm1_q}, m_q);
      if (state_q == S_RUN) begin
         // Arithmetic shift of {sum, Q, q_m1} right by two.
         a_d   = {{2{sum[W]}}, sum[W:2]};
         q_d   = {sum[1:0], q_q[W-1:2]};
         qm1_d = q_q[1];
         cnt_d = cnt_q - LAST;
         // Final digit: the low 2N bits of the shifted {A,Q} are the product.
         if (cnt_q == LAST) begin
            prod_d = {sum[W-3:2], q_d};
         end
      end else if (accept) begin
         m_d   = extend_op(multiplicand, signed_mode);
         q_d   = extend_op(multiplier, signed_mode);
         a_d   = '0;
         qm1_d = 1'b0;
         cnt_d = ITERS;
      end
   end

   // Datapath registers; reset also aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         q_q    <= '0;
         qm1_q  <= 1'b0;
         m_q    <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
      end else begin
         a_q    <= a_d;
         q_q    <= q_d;
         qm1_q  <= qm1_d;
         m_q    <= m_d;
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
      end
   end

   assign product = prod_q;

endmodule
